// File: rtl/cdb_pkg.sv
// Shared common-data-bus types and tag constants.
// Imported by the CDB arbiter, its port FIFOs and the bench.
package cdb_pkg;

    localparam int UNIT_SIZE = 8;
    localparam int WORD_SIZE = 32;

    // Tag meaning "register already holds its value"; never broadcast.
    localparam logic [UNIT_SIZE-1:0] TAG_VALUE_PRESENT = 8'h7F;

    localparam logic [UNIT_SIZE-1:0] LW_TAG_BASE  = 8'h80;
    localparam logic [UNIT_SIZE-1:0] ADD_TAG_BASE = 8'hA0;
    localparam logic [UNIT_SIZE-1:0] MUL_TAG_BASE = 8'hC0;
    localparam logic [UNIT_SIZE-1:0] SW_TAG_BASE  = 8'h00;

    typedef struct packed {
        logic [UNIT_SIZE-1:0] tag;
        logic [WORD_SIZE-1:0] data;
    } cdb_msg_t;

endpackage

// File: rtl/cdb_port_fifo.sv
// Per-port result buffer in front of the CDB arbiter.
// Registered count; contents are only valid below count.
module cdb_port_fifo
    import cdb_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  cdb_msg_t      i_msg,
    input  logic          i_pop,
    output cdb_msg_t      o_head,
    output logic [CW-1:0] o_count
);

    cdb_msg_t      r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_msg;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= f_inc(r_wr_ptr);
            end
            if (i_pop) begin
                r_rd_ptr <= f_inc(r_rd_ptr);
            end
            unique case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin common-data-bus arbiter: one buffered result per cycle
// is driven onto a registered broadcast.
module cdb_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int UNIT_SIZE = 8,
    parameter int WORD_SIZE = 32,
    parameter int DEPTH     = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_PORTS-1:0]           req_valid,
    output logic [NUM_PORTS-1:0]           req_ready,
    input  logic [NUM_PORTS*UNIT_SIZE-1:0] req_tag,
    input  logic [NUM_PORTS*WORD_SIZE-1:0] req_data,
    input  logic                           cdb_hold,
    output logic                           cdb_valid,
    output logic [UNIT_SIZE-1:0]           cdb_tag,
    output logic [WORD_SIZE-1:0]           cdb_data,
    output logic                           drop_pulse
);

    import cdb_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);
    localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    cdb_msg_t             w_head  [NUM_PORTS];
    logic [CW-1:0]        w_count [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_cand;
    logic [NUM_PORTS-1:0] w_push;
    logic [NUM_PORTS-1:0] w_pop;
    logic [NUM_PORTS-1:0] w_rsvd;
    logic [GW-1:0]        w_win;
    logic [GW-1:0]        w_idx;
    logic                 w_found;
    logic                 w_grant;

    logic [GW-1:0]        r_last;
    logic                 r_valid;
    logic [UNIT_SIZE-1:0] r_tag;
    logic [WORD_SIZE-1:0] r_data;
    logic                 r_drop;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [UNIT_SIZE-1:0] w_tag;
        cdb_msg_t             w_msg;

        assign w_tag        = req_tag[p*UNIT_SIZE +: UNIT_SIZE];
        assign w_msg.tag    = w_tag;
        assign w_msg.data   = req_data[p*WORD_SIZE +: WORD_SIZE];
        // Ready looks at the registered count only: no pass-through.
        assign req_ready[p] = rst_n && (w_count[p] != CW'(DEPTH));
        assign w_rsvd[p]    = (w_tag == TAG_VALUE_PRESENT);
        assign w_push[p]    = req_valid[p] && req_ready[p] && !w_rsvd[p];
        assign w_cand[p]    = (w_count[p] != '0);
        assign w_pop[p]     = w_grant && (w_win == GW'(p));

        cdb_port_fifo #(
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_push  (w_push[p]),
            .i_msg   (w_msg),
            .i_pop   (w_pop[p]),
            .o_head  (w_head[p]),
            .o_count (w_count[p])
        );
    end

    // Search begins one past the last winner and wraps.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_last;
        w_idx   = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            w_idx = GW'((int'(r_last) + i) % NUM_PORTS);
            if (!w_found && w_cand[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_grant = w_found && !cdb_hold;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last  <= GW'(NUM_PORTS - 1);
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_data  <= '0;
            r_drop  <= 1'b0;
        end else begin
            r_drop  <= |(req_valid & req_ready & w_rsvd);
            r_valid <= w_grant;
            if (w_grant) begin
                r_last <= w_win;
                r_tag  <= w_head[w_win].tag;
                r_data <= w_head[w_win].data;
            end
        end
    end

    assign cdb_valid  = r_valid;
    assign cdb_tag    = r_tag;
    assign cdb_data   = r_data;
    assign drop_pulse = r_drop;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scenario bench for cdb_arbiter with an expected-broadcast queue.
module tb_cdb_arbiter;

    import cdb_pkg::*;

    localparam int NP = 4;
    localparam int US = 8;
    localparam int WS = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NP-1:0]  req_valid;
    logic [NP-1:0]  req_ready;
    logic [NP*US-1:0] req_tag;
    logic [NP*WS-1:0] req_data;
    logic           cdb_hold;
    logic           cdb_valid;
    logic [US-1:0]  cdb_tag;
    logic [WS-1:0]  cdb_data;
    logic           drop_pulse;

    int checks   = 0;
    int failures = 0;
    logic [US+WS-1:0] exp_q [$];

    cdb_arbiter #(
        .NUM_PORTS (NP),
        .UNIT_SIZE (US),
        .WORD_SIZE (WS),
        .DEPTH     (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_tag    (req_tag),
        .req_data   (req_data),
        .cdb_hold   (cdb_hold),
        .cdb_valid  (cdb_valid),
        .cdb_tag    (cdb_tag),
        .cdb_data   (cdb_data),
        .drop_pulse (drop_pulse)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int p, input logic v,
                         input logic [US-1:0] t, input logic [WS-1:0] d);
        req_valid[p]         = v;
        req_tag[p*US +: US]  = t;
        req_data[p*WS +: WS] = d;
    endtask

    task automatic idle_all();
        for (int p = 0; p < NP; p++) drive(p, 1'b0, '0, '0);
    endtask

    function automatic logic [US-1:0] tagf(input int p, input int k);
        logic [US-1:0] b;
        case (p)
            0:       b = LW_TAG_BASE;
            1:       b = ADD_TAG_BASE;
            2:       b = MUL_TAG_BASE;
            default: b = SW_TAG_BASE;
        endcase
        return b + US'(k + 1);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        cdb_hold = 1'b0;
        idle_all();
        step();
        step();
        checks++;
        if (cdb_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid: got %b want 0", cdb_valid);
        end
        checks++;
        if (cdb_tag !== '0 || cdb_data !== '0) begin
            failures++;
            $display("FAIL reset_bus: got %h/%h want 0/0", cdb_tag, cdb_data);
        end
        checks++;
        if (drop_pulse !== 1'b0) begin
            failures++;
            $display("FAIL reset_drop: got %b want 0", drop_pulse);
        end
        checks++;
        if (req_ready !== 4'h0) begin
            failures++;
            $display("FAIL reset_ready: got %h want 0", req_ready);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'hF) begin
            failures++;
            $display("FAIL release_ready: got %h want f", req_ready);
        end
    endtask

    task automatic test_single();
        logic [US+WS-1:0] e;
        drive(1, 1'b1, 8'hA3, 32'd42);
        exp_q.push_back({8'hA3, 32'd42});
        step();
        idle_all();
        checks++;
        if (cdb_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_early: got valid %b want 0", cdb_valid);
        end
        step();
        e = exp_q.pop_front();
        checks++;
        if ({cdb_valid, cdb_tag, cdb_data} !== {1'b1, e}) begin
            failures++;
            $display("FAIL single_out: got v=%b %h/%h want 1 %h/%h",
                     cdb_valid, cdb_tag, cdb_data, e[WS+:US], e[WS-1:0]);
        end
        step();
        checks++;
        if (cdb_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_once: got valid %b want 0", cdb_valid);
        end
    endtask

    task automatic run_stream(input string nm, input logic [NP-1:0] en,
                              input int n, input int budget);
        int idx [NP];
        int nv = 0, first = -1, last = -1;
        logic [NP-1:0] acc;
        logic [US+WS-1:0] e;
        for (int p = 0; p < NP; p++) idx[p] = 0;
        for (int k = 0; k < n; k++)
            for (int p = 0; p < NP; p++)
                if (en[p]) exp_q.push_back({tagf(p, k), WS'(p * 100 + k)});
        for (int c = 0; c < budget; c++) begin
            for (int p = 0; p < NP; p++)
                if (en[p] && idx[p] < n)
                    drive(p, 1'b1, tagf(p, idx[p]), WS'(p * 100 + idx[p]));
                else
                    drive(p, 1'b0, '0, '0);
            #1;
            acc = req_valid & req_ready;
            step();
            for (int p = 0; p < NP; p++) if (acc[p]) idx[p]++;
            if (cdb_valid) begin
                nv++;
                if (first < 0) first = c;
                last = c;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL %s_extra: got %h/%h want none",
                             nm, cdb_tag, cdb_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({cdb_tag, cdb_data} !== e) begin
                        failures++;
                        $display("FAIL %s_order: got %h/%h want %h/%h",
                                 nm, cdb_tag, cdb_data, e[WS+:US], e[WS-1:0]);
                    end
                end
            end
        end
        idle_all();
        checks++;
        if (nv != n * $countones(en) || last - first != nv - 1) begin
            failures++;
            $display("FAIL %s_span: got %0d valid over %0d cycles want %0d back-to-back",
                     nm, nv, last - first + 1, n * $countones(en));
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_left: got %0d pending want 0", nm, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_fairness();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        run_stream("fair", 4'hF, 3, 24);
    endtask

    task automatic test_back_to_back();
        run_stream("b2b", 4'b1000, 4, 12);
    endtask

    task automatic test_full_port();
        int idx = 0;
        int nv = 0;
        logic acc;
        logic [US+WS-1:0] e;
        for (int k = 0; k < 3; k++) exp_q.push_back({tagf(2, k), WS'(k)});
        cdb_hold = 1'b1;
        for (int c = 0; c < 17; c++) begin
            if (c == 5) begin
                checks++;
                if (idx != 2 || req_ready[2] !== 1'b0) begin
                    failures++;
                    $display("FAIL full_stall: got %0d accepts ready=%b want 2 ready=0",
                             idx, req_ready[2]);
                end
                cdb_hold = 1'b0;
            end
            if (idx < 3) drive(2, 1'b1, tagf(2, idx), WS'(idx));
            else drive(2, 1'b0, '0, '0);
            #1;
            acc = req_valid[2] && req_ready[2];
            step();
            if (acc) idx++;
            if (cdb_valid) begin
                nv++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL full_extra: got %h want none", cdb_tag);
                end else begin
                    e = exp_q.pop_front();
                    if (c < 5 || {cdb_tag, cdb_data} !== e) begin
                        failures++;
                        $display("FAIL full_order: got %h/%h at %0d want %h/%h",
                                 cdb_tag, cdb_data, c, e[WS+:US], e[WS-1:0]);
                    end
                end
            end
        end
        idle_all();
        checks++;
        if (nv != 3 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL full_count: got %0d broadcasts want 3", nv);
            exp_q.delete();
        end
    endtask

    task automatic test_hold();
        logic [US+WS-1:0] e;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        cdb_hold = 1'b1;
        drive(0, 1'b1, 8'h80, 32'd10);
        drive(1, 1'b1, 8'hA0, 32'd20);
        step();
        drive(0, 1'b1, 8'h81, 32'd11);
        drive(1, 1'b1, 8'hA1, 32'd21);
        step();
        idle_all();
        exp_q.push_back({8'h80, 32'd10});
        exp_q.push_back({8'hA0, 32'd20});
        exp_q.push_back({8'h81, 32'd11});
        exp_q.push_back({8'hA1, 32'd21});
        checks++;
        if (cdb_valid !== 1'b0) begin
            failures++;
            $display("FAIL hold_load: got valid %b want 0", cdb_valid);
        end
        cdb_hold = 1'b0;
        step();
        e = exp_q.pop_front();
        checks++;
        if ({cdb_valid, cdb_tag, cdb_data} !== {1'b1, e}) begin
            failures++;
            $display("FAIL hold_first: got v=%b %h want %h", cdb_valid, cdb_tag, e[WS+:US]);
        end
        cdb_hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if ({cdb_valid, cdb_tag, cdb_data} !== {1'b0, e}) begin
                failures++;
                $display("FAIL hold_idle: got v=%b %h/%h want 0 %h/%h",
                         cdb_valid, cdb_tag, cdb_data, e[WS+:US], e[WS-1:0]);
            end
        end
        cdb_hold = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            e = exp_q.pop_front();
            checks++;
            if ({cdb_valid, cdb_tag, cdb_data} !== {1'b1, e}) begin
                failures++;
                $display("FAIL hold_resume: got v=%b %h want %h",
                         cdb_valid, cdb_tag, e[WS+:US]);
            end
        end
    endtask

    task automatic test_reserved();
        int nv = 0;
        drive(0, 1'b1, TAG_VALUE_PRESENT, 32'd5);
        #1;
        checks++;
        if (req_ready[0] !== 1'b1) begin
            failures++;
            $display("FAIL rsvd_ready: got %b want 1", req_ready[0]);
        end
        step();
        idle_all();
        checks++;
        if (drop_pulse !== 1'b1) begin
            failures++;
            $display("FAIL rsvd_pulse: got %b want 1", drop_pulse);
        end
        for (int c = 0; c < 6; c++) begin
            if (cdb_valid) nv++;
            step();
            if (c == 0) begin
                checks++;
                if (drop_pulse !== 1'b0) begin
                    failures++;
                    $display("FAIL rsvd_width: got %b want 0", drop_pulse);
                end
            end
        end
        checks++;
        if (nv != 0) begin
            failures++;
            $display("FAIL rsvd_bcast: got %0d broadcasts want 0", nv);
        end
    endtask

    task automatic test_reset_burst();
        int nv = 0;
        cdb_hold = 1'b1;
        drive(0, 1'b1, 8'h90, 32'd1);
        drive(1, 1'b1, 8'hB0, 32'd2);
        drive(2, 1'b1, 8'hD0, 32'd3);
        step();
        drive(0, 1'b1, 8'h91, 32'd4);
        drive(1, 1'b1, 8'hB1, 32'd5);
        drive(2, 1'b0, '0, '0);
        step();
        idle_all();
        cdb_hold = 1'b0;
        rst_n = 1'b0;
        step();
        checks++;
        if ({cdb_valid, req_ready} !== 5'b0) begin
            failures++;
            $display("FAIL burst_reset: got v=%b ready=%h want 0/0", cdb_valid, req_ready);
        end
        checks++;
        if (cdb_tag !== '0 || cdb_data !== '0) begin
            failures++;
            $display("FAIL burst_bus: got %h/%h want 0/0", cdb_tag, cdb_data);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            if (cdb_valid) nv++;
        end
        checks++;
        if (nv != 0 || req_ready !== 4'hF) begin
            failures++;
            $display("FAIL burst_stale: got %0d broadcasts ready=%h want 0 f",
                     nv, req_ready);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        cdb_hold  = 1'b0;
        req_valid = '0;
        req_tag   = '0;
        req_data  = '0;
        test_reset();
        test_single();
        test_fairness();
        test_back_to_back();
        test_full_port();
        test_hold();
        test_reserved();
        test_reset_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
